dram_cmd_scheduler: RTL and testbench



---
 rtl/dram_pkg.sv | 41 ++++
 rtl/dram_open_row_table.sv | 49 ++++
 rtl/dram_cmd_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command scheduler.
//   cmd_e    : DRAM command encodings driven on the cmd port
//   state_e  : scheduler FSM states
//   id_width : bit width of an index into n items (minimum 1)
//   is_rw    : true for column commands (READ/WRITE)
//   rw_cmd   : maps the request direction to its column command
package dram_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_PRE = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_ISSUE,
    S_WAIT_ACK_HI,
    S_WAIT_ACK_LO,
    S_FLUSH_SCAN,
    S_DONE
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_rw(input cmd_e c);
    return (c == CMD_RD) || (c == CMD_WR);
  endfunction

  function automatic cmd_e rw_cmd(input logic rw);
    cmd_e c;
    if (rw) c = CMD_WR;
    else    c = CMD_RD;
    return c;
  endfunction

endpackage

// File: rtl/dram_open_row_table.sv
// Open-row table: one valid bit and one row id per bank.
//   clk, rst_b         : clock, asynchronous active-low reset (clears every entry)
//   lk_bank, lk_row    : combinational lookup key
//   lk_valid, lk_hit   : bank has an open row / open row equals lk_row
//   wr_set, wr_clr     : open (set valid + row) or close (clear valid) wr_bank;
//                        clear wins if both are asserted
//   wr_bank, wr_row    : write-port target
module dram_open_row_table
  import dram_pkg::*;
#(
  parameter  int NUM_OF_BANKS = 8,
  parameter  int NUM_OF_ROWS  = 128,
  localparam int BW           = id_width(NUM_OF_BANKS),
  localparam int RW           = id_width(NUM_OF_ROWS)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [BW-1:0] lk_bank,
  input  logic [RW-1:0] lk_row,
  output logic          lk_valid,
  output logic          lk_hit,
  input  logic          wr_set,
  input  logic          wr_clr,
  input  logic [BW-1:0] wr_bank,
  input  logic [RW-1:0] wr_row
);

  logic [NUM_OF_BANKS-1:0] valid_q;
  logic [RW-1:0]           row_q [NUM_OF_BANKS];

  // NOTE: the row array is flop storage rather than a RAM macro, so it can
  // take the asynchronous clear along with the valid bits; only valid_q
  // actually qualifies a hit, the row clear just keeps the contents defined.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) row_q[i] <= '0;
    end else if (wr_clr) begin
      valid_q[wr_bank] <= 1'b0;
    end else if (wr_set) begin
      valid_q[wr_bank] <= 1'b1;
      row_q[wr_bank]   <= wr_row;
    end
  end

  assign lk_valid = valid_q[lk_bank];
  assign lk_hit   = lk_valid && (row_q[lk_bank] == lk_row);

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Open-page DRAM command scheduler.
// Takes one decoded access at a time, looks up the bank's open row and emits
// the minimal PRE/ACT/RD/WR sequence over a four-phase cmd_req/cmd_ack
// handshake. A flush closes every open bank. Row hits and misses are counted.
//   clk, rst_b                         : clock, asynchronous active-low reset
//   req_valid/req_ready                : request handshake
//   req_rw, req_bank, req_row, req_col : access (rw: 1 = write)
//   flush                              : level request to close all rows (IDLE only)
//   cmd_req/cmd_ack                    : four-phase command handshake
//   cmd, bank_id, row_id, col_id       : command payload, stable through handshake
//   op_done, flush_done                : single-cycle completion pulses
//   hit_cnt, miss_cnt                  : saturating statistics
//   err_timeout                        : sticky ack-timeout flag
module dram_cmd_scheduler
  import dram_pkg::*;
#(
  parameter  int NUM_OF_BANKS = 8,
  parameter  int NUM_OF_ROWS  = 128,
  parameter  int NUM_OF_COLS  = 8,
  parameter  int ACK_TIMEOUT  = 64,
  parameter  int STAT_WIDTH   = 16,
  localparam int BW           = id_width(NUM_OF_BANKS),
  localparam int RW           = id_width(NUM_OF_ROWS),
  localparam int CW           = id_width(NUM_OF_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [BW-1:0]         req_bank,
  input  logic [RW-1:0]         req_row,
  input  logic [CW-1:0]         req_col,
  input  logic                  flush,
  output logic                  cmd_req,
  input  logic                  cmd_ack,
  output logic [1:0]            cmd,
  output logic [BW-1:0]         bank_id,
  output logic [RW-1:0]         row_id,
  output logic [CW-1:0]         col_id,
  output logic                  op_done,
  output logic                  flush_done,
  output logic [STAT_WIDTH-1:0] hit_cnt,
  output logic [STAT_WIDTH-1:0] miss_cnt,
  output logic                  err_timeout
);

  localparam int TW = id_width(ACK_TIMEOUT + 1);

  state_e                state_q, state_d;
  cmd_e                  cur_cmd_q;
  logic                  rw_q;
  logic [BW-1:0]         bank_q, scan_idx_q;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         col_q;
  logic                  flushing_q, started_q, err_q;
  logic [TW-1:0]         tmo_cnt_q;
  logic [STAT_WIDTH-1:0] hit_q, miss_q;

  logic          lk_valid, lk_hit;
  logic [BW-1:0] lk_bank;
  logic          accept, flush_go, waiting, ack_hi_seen, ack_lo_done;
  logic          timeout_fire, last_bank, tbl_set, tbl_clr;

  // During a flush the table is probed at the scan index; otherwise at the
  // latched request's bank.
  assign lk_bank     = (state_q == S_FLUSH_SCAN) ? scan_idx_q : bank_q;
  assign last_bank   = (scan_idx_q == BW'(NUM_OF_BANKS - 1));
  assign flush_go    = (state_q == S_IDLE) && started_q && flush;
  assign accept      = req_valid && req_ready;
  assign waiting     = (state_q == S_WAIT_ACK_HI) || (state_q == S_WAIT_ACK_LO);
  assign ack_hi_seen = (state_q == S_WAIT_ACK_HI) && cmd_ack;
  assign ack_lo_done = (state_q == S_WAIT_ACK_LO) && !cmd_ack;
  // A legitimate ack edge in the final cycle still wins over the timeout.
  assign timeout_fire = waiting && (tmo_cnt_q == TW'(ACK_TIMEOUT - 1))
                        && !ack_hi_seen && !ack_lo_done;

  assign tbl_set = ack_lo_done && (cur_cmd_q == CMD_ACT);
  assign tbl_clr = (ack_lo_done && (cur_cmd_q == CMD_PRE)) || timeout_fire;

  dram_open_row_table #(
    .NUM_OF_BANKS (NUM_OF_BANKS),
    .NUM_OF_ROWS  (NUM_OF_ROWS)
  ) u_table (
    .clk      (clk),
    .rst_b    (rst_b),
    .lk_bank  (lk_bank),
    .lk_row   (row_q),
    .lk_valid (lk_valid),
    .lk_hit   (lk_hit),
    .wr_set   (tbl_set),
    .wr_clr   (tbl_clr),
    .wr_bank  (bank_q),
    .wr_row   (row_q)
  );

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush_go)    state_d = S_FLUSH_SCAN;
        else if (accept) state_d = S_DECIDE;
      end
      S_DECIDE: state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT_ACK_HI;
      S_WAIT_ACK_HI: begin
        if (cmd_ack)           state_d = S_WAIT_ACK_LO;
        else if (timeout_fire) state_d = S_IDLE;
      end
      S_WAIT_ACK_LO: begin
        if (!cmd_ack) begin
          if (flushing_q)            state_d = S_FLUSH_SCAN;
          else if (is_rw(cur_cmd_q)) state_d = S_DONE;
          else                       state_d = S_ISSUE;
        end else if (timeout_fire) begin
          state_d = S_IDLE;
        end
      end
      // A bank just precharged reads back closed on return, so the scan
      // index only advances past banks that are already closed.
      S_FLUSH_SCAN: begin
        if (lk_valid)       state_d = S_ISSUE;
        else if (last_bank) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    cmd_req    = 1'b0;
    op_done    = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE:                 req_ready = started_q && !flush;
      S_ISSUE, S_WAIT_ACK_HI: cmd_req   = 1'b1;
      S_DONE: begin
        op_done    = !flushing_q;
        flush_done = flushing_q;
      end
      default: ;
    endcase
  end

  // Ack-edge watchdog: counts cycles spent in the current wait state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                           tmo_cnt_q <= '0;
    else if (!waiting || state_d != state_q) tmo_cnt_q <= '0;
    else                                  tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cur_cmd_q  <= CMD_ACT;
      rw_q       <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      scan_idx_q <= '0;
      flushing_q <= 1'b0;
      started_q  <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      started_q <= 1'b1;
      if (timeout_fire) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (flush_go) begin
            flushing_q <= 1'b1;
            scan_idx_q <= '0;
          end else if (accept) begin
            rw_q   <= req_rw;
            bank_q <= req_bank;
            row_q  <= req_row;
            col_q  <= req_col;
          end
        end
        S_DECIDE: begin
          if (lk_hit) begin
            cur_cmd_q <= rw_cmd(rw_q);
            if (hit_q != '1) hit_q <= hit_q + STAT_WIDTH'(1);
          end else begin
            cur_cmd_q <= lk_valid ? CMD_PRE : CMD_ACT;
            if (miss_q != '1) miss_q <= miss_q + STAT_WIDTH'(1);
          end
        end
        S_FLUSH_SCAN: begin
          if (lk_valid) begin
            bank_q    <= scan_idx_q;
            cur_cmd_q <= CMD_PRE;
          end else if (!last_bank) begin
            scan_idx_q <= scan_idx_q + BW'(1);
          end
        end
        S_WAIT_ACK_LO: begin
          if (ack_lo_done) begin
            if (cur_cmd_q == CMD_PRE && !flushing_q) cur_cmd_q <= CMD_ACT;
            else if (cur_cmd_q == CMD_ACT)           cur_cmd_q <= rw_cmd(rw_q);
          end
        end
        S_DONE:  flushing_q <= 1'b0;
        default: ;
      endcase
      // A timeout abandons whatever was in flight, including a flush.
      if (timeout_fire) flushing_q <= 1'b0;
    end
  end

  assign cmd         = cur_cmd_q;
  assign bank_id     = bank_q;
  assign row_id      = row_q;
  assign col_id      = col_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench for dram_cmd_scheduler: directed accesses with
// hand-computed command sequences pushed into a scoreboard queue; a monitor
// pops and compares on every cmd_req rise, op_done and flush_done.
module tb_dram_cmd_scheduler;
  import dram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [2:0]  req_bank = '0;
  logic [6:0]  req_row = '0;
  logic [2:0]  req_col = '0;
  logic        flush = 1'b0;
  logic        cmd_req;
  logic        cmd_ack = 1'b0;
  logic [1:0]  cmd;
  logic [2:0]  bank_id;
  logic [6:0]  row_id;
  logic [2:0]  col_id;
  logic        op_done, flush_done;
  logic [15:0] hit_cnt, miss_cnt;
  logic        err_timeout;

  always #5 clk = ~clk;

  dram_cmd_scheduler dut (
    .clk (clk), .rst_b (rst_b),
    .req_valid (req_valid), .req_ready (req_ready), .req_rw (req_rw),
    .req_bank (req_bank), .req_row (req_row), .req_col (req_col),
    .flush (flush), .cmd_req (cmd_req), .cmd_ack (cmd_ack), .cmd (cmd),
    .bank_id (bank_id), .row_id (row_id), .col_id (col_id),
    .op_done (op_done), .flush_done (flush_done),
    .hit_cnt (hit_cnt), .miss_cnt (miss_cnt), .err_timeout (err_timeout)
  );

  typedef enum logic [1:0] {EV_CMD, EV_OP, EV_FLUSH} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [1:0] cmd;
    logic [2:0] bank;
    logic [6:0] row;
    logic [2:0] col;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;
  bit  ack_en = 1'b1;
  bit  hold_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_ev(input logic [1:0] k, input logic [1:0] c,
                                          input logic [2:0] b, input logic [6:0] r,
                                          input logic [2:0] col);
    return {49'd0, k, c, b, r, col};
  endfunction

  // Row only matters for ACT, column only for READ/WRITE.
  task automatic exp_cmd(input logic [1:0] c, input int b, input int r, input int col);
    ev_t e;
    e.kind = EV_CMD;
    e.cmd  = c;
    e.bank = 3'(b);
    e.row  = (c == CMD_ACT) ? 7'(r) : 7'd0;
    e.col  = (c == CMD_RD || c == CMD_WR) ? 3'(col) : 3'd0;
    sb.push_back(e);
  endtask

  task automatic exp_ev(input ev_kind_e k);
    ev_t e;
    e.kind = k;
    e.cmd  = '0;
    e.bank = '0;
    e.row  = '0;
    e.col  = '0;
    sb.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input string what);
    ev_t        e;
    logic [6:0] r;
    logic [2:0] c;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got cmd=%0d bank=%0d row=%0d col=%0d, want nothing (t=%0t)",
               what, cmd, bank_id, row_id, col_id, $time);
    end else begin
      e = sb.pop_front();
      r = (k == EV_CMD && cmd == CMD_ACT) ? row_id : 7'd0;
      c = (k == EV_CMD && (cmd == CMD_RD || cmd == CMD_WR)) ? col_id : 3'd0;
      if (k == EV_CMD)
        check({"sb_", what}, pack_ev(k, cmd, bank_id, r, c),
              pack_ev(e.kind, e.cmd, e.bank, e.row, e.col));
      else
        check({"sb_", what}, pack_ev(k, 2'd0, 3'd0, 7'd0, 3'd0),
              pack_ev(e.kind, e.cmd, e.bank, e.row, e.col));
    end
  endtask

  initial begin : monitor
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_req && !prev_req) observe(EV_CMD, "cmd");
      if (op_done)              observe(EV_OP, "op_done");
      if (flush_done)           observe(EV_FLUSH, "flush_done");
      prev_req = cmd_req;
    end
  end

  // DRAM-side responder: ack one cycle after cmd_req, drop ack once cmd_req
  // falls unless hold_ack keeps it high.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (cmd_req && ack_en && !cmd_ack) begin
        @(negedge clk);
        cmd_ack = 1'b1;
        for (int i = 0; i < 200 && cmd_req; i++) @(negedge clk);
        for (int i = 0; i < 5000 && hold_ack; i++) @(negedge clk);
        cmd_ack = 1'b0;
      end
    end
  end

  task automatic send_req(input string name, input logic rw, input int b, input int r, input int c);
    @(negedge clk);
    req_rw    = rw;
    req_bank  = 3'(b);
    req_row   = 7'(r);
    req_col   = 3'(c);
    req_valid = 1'b1;
    for (int n = 0; n < 300 && !req_ready; n++) @(negedge clk);
    check({name, "_accept"}, req_ready, 1'b1);
    if (req_ready) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_op(input string name, output int ready_hi);
    ready_hi = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (op_done) break;
      if (req_ready) ready_hi++;
    end
    check({name, "_op_done"}, op_done, 1'b1);
  endtask

  task automatic do_flush(input string name, output int cycles);
    @(negedge clk);
    flush  = 1'b1;
    cycles = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      flush = 1'b0;
      if (flush_done) break;
    end
    check({name, "_flush_done"}, flush_done, 1'b1);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int  rh, n;
    bit  seen_fd;

    // Reset state.
    #1;
    check("reset_outputs",
          {req_ready, cmd_req, cmd, bank_id, row_id, col_id, op_done, flush_done,
           hit_cnt, miss_cnt, err_timeout}, '0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    #1 check("ready_before_first_clk", req_ready, 1'b0);
    @(posedge clk);
    #1 check("ready_after_first_clk", req_ready, 1'b1);

    // Flush with nothing open: NUM_OF_BANKS + 1 cycles, no commands.
    exp_ev(EV_FLUSH);
    do_flush("empty_flush", n);
    check("empty_flush_cycles", n, 9);

    // Empty-bank miss.
    exp_cmd(CMD_ACT, 2, 5, 0);
    exp_cmd(CMD_RD, 2, 0, 3);
    exp_ev(EV_OP);
    send_req("rd_b2r5", 1'b0, 2, 5, 3);
    wait_op("rd_b2r5", rh);
    check("miss_after_empty", miss_cnt, 16'd1);
    check("hit_after_empty", hit_cnt, 16'd0);

    // Row hit.
    exp_cmd(CMD_WR, 2, 0, 1);
    exp_ev(EV_OP);
    send_req("wr_b2r5", 1'b1, 2, 5, 1);
    wait_op("wr_b2r5", rh);
    check("hit_after_hit", hit_cnt, 16'd1);

    // Row conflict; ready must stay low for the whole sequence.
    exp_cmd(CMD_PRE, 2, 0, 0);
    exp_cmd(CMD_ACT, 2, 9, 0);
    exp_cmd(CMD_RD, 2, 0, 0);
    exp_ev(EV_OP);
    send_req("rd_b2r9", 1'b0, 2, 9, 0);
    wait_op("rd_b2r9", rh);
    check("conflict_ready_low", rh, 0);
    check("miss_after_conflict", miss_cnt, 16'd2);

    // Close bank 2 so only the banks opened below are open.
    exp_cmd(CMD_PRE, 2, 0, 0);
    exp_ev(EV_FLUSH);
    do_flush("flush_b2", n);
    check("miss_after_flush", miss_cnt, 16'd2);

    // Open banks 0, 3, 7 (bank/row/col extremes included).
    exp_cmd(CMD_ACT, 0, 1, 0);   exp_cmd(CMD_RD, 0, 0, 0);   exp_ev(EV_OP);
    send_req("open_b0", 1'b0, 0, 1, 0);   wait_op("open_b0", rh);
    exp_cmd(CMD_ACT, 3, 4, 0);   exp_cmd(CMD_WR, 3, 0, 2);   exp_ev(EV_OP);
    send_req("open_b3", 1'b1, 3, 4, 2);   wait_op("open_b3", rh);
    exp_cmd(CMD_ACT, 7, 127, 0); exp_cmd(CMD_RD, 7, 0, 7);   exp_ev(EV_OP);
    send_req("open_b7", 1'b0, 7, 127, 7); wait_op("open_b7", rh);
    check("miss_after_opens", miss_cnt, 16'd5);

    // Flush together with a request: flush first, then an empty-bank miss.
    exp_cmd(CMD_PRE, 0, 0, 0);
    exp_cmd(CMD_PRE, 3, 0, 0);
    exp_cmd(CMD_PRE, 7, 0, 0);
    exp_ev(EV_FLUSH);
    exp_cmd(CMD_ACT, 3, 4, 0);
    exp_cmd(CMD_RD, 3, 0, 5);
    exp_ev(EV_OP);
    @(negedge clk);
    req_rw = 1'b0; req_bank = 3'd3; req_row = 7'd4; req_col = 3'd5;
    req_valid = 1'b1;
    flush = 1'b1;
    #1 check("ready_low_with_flush", req_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    seen_fd = 1'b0;
    for (int k = 0; k < 300 && !req_ready; k++) begin
      @(negedge clk);
      if (flush_done) seen_fd = 1'b1;
    end
    check("flush_before_accept", seen_fd, 1'b1);
    check("flush_req_accept", req_ready, 1'b1);
    if (req_ready) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_op("post_flush_rd", rh);
    check("miss_after_flush_req", miss_cnt, 16'd6);

    // Ack never arrives on an ACT.
    ack_en = 1'b0;
    exp_cmd(CMD_ACT, 5, 10, 0);
    send_req("tmo", 1'b0, 5, 10, 0);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_req) n++;
      else if (n > 0) break;
    end
    check("tmo_req_cycles_in_range", (n >= 64 && n <= 66), 1'b1);
    check("tmo_err", err_timeout, 1'b1);
    check("tmo_cmd_req_low", cmd_req, 1'b0);
    check("tmo_ready_back", req_ready, 1'b1);
    ack_en = 1'b1;

    exp_cmd(CMD_ACT, 5, 10, 0);
    exp_cmd(CMD_RD, 5, 0, 1);
    exp_ev(EV_OP);
    send_req("after_tmo", 1'b0, 5, 10, 1);
    wait_op("after_tmo", rh);
    check("err_sticky", err_timeout, 1'b1);
    check("miss_after_tmo", miss_cnt, 16'd8);

    // Reset while the FSM waits for ack to fall.
    hold_ack = 1'b1;
    exp_cmd(CMD_WR, 3, 0, 6);
    send_req("rst_mid", 1'b1, 3, 4, 6);
    for (int k = 0; k < 100 && !(cmd_ack && !cmd_req); k++) @(negedge clk);
    check("reached_wait_ack_lo", (cmd_ack && !cmd_req), 1'b1);
    check("hit_before_rst", hit_cnt, 16'd2);
    #2 rst_b = 1'b0;
    #1 check("rst_mid_outputs",
             {req_ready, cmd_req, cmd, bank_id, row_id, col_id, op_done, flush_done,
              hit_cnt, miss_cnt, err_timeout}, '0);
    hold_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    exp_cmd(CMD_ACT, 3, 4, 0);
    exp_cmd(CMD_RD, 3, 0, 2);
    exp_ev(EV_OP);
    send_req("post_rst", 1'b0, 3, 4, 2);
    wait_op("post_rst", rh);
    check("miss_post_rst", miss_cnt, 16'd1);
    check("hit_post_rst", hit_cnt, 16'd0);
    check("err_post_rst", err_timeout, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
